// File: rtl/pc_gen.sv
// Program-counter unit for the NPC core: owns the fetch PC and picks the next fetch
// address from branches, JAL/JALR, external redirects, misaligned-target traps and halt.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h8000_0100,
    parameter bit              C_EXT     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            branch,
    input  logic [2:0]      br_funct3,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            halt,
    output logic [XLEN-1:0] next_pc,
    output logic            taken,
    output logic            misalign,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] bad_addr,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] SEQ_INC = XLEN'(32'd4);
    localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(32'd1);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            halted_q;
    logic            misalign_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] bad_addr_q;
    logic            pend_valid_q;
    logic [XLEN-1:0] pend_pc_q;

    logic            br_cond_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] jalr_tgt_s;
    logic [XLEN-1:0] rel_tgt_s;
    logic [XLEN-1:0] seq_pc_s;
    logic [XLEN-1:0] jump_tgt_s;
    logic            taken_s;
    logic            trap_s;
    logic            trap_win_s;
    logic            advance_s;
    logic [XLEN-1:0] pc_d;

    // Branch condition evaluation; 010/011 are never taken
    always_comb begin
        br_cond_s = 1'b0;
        case (br_funct3)
            3'b000:  br_cond_s = (rs1_val == rs2_val);
            3'b001:  br_cond_s = (rs1_val != rs2_val);
            3'b100:  br_cond_s = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_cond_s = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond_s = (rs1_val <  rs2_val);
            3'b111:  br_cond_s = (rs1_val >= rs2_val);
            default: br_cond_s = 1'b0;
        endcase
    end

    // Jump/branch target computation and alignment check
    always_comb begin
        jalr_sum_s = rs1_val + imm;
        jalr_tgt_s = jalr_sum_s & LSB_CLR;
        rel_tgt_s  = pc_q + imm;
        seq_pc_s   = pc_q + SEQ_INC;
        taken_s    = jalr | jal | (branch & br_cond_s);
        if (jalr) begin
            jump_tgt_s = jalr_tgt_s;
        end else begin
            jump_tgt_s = rel_tgt_s;
        end
        // JALR targets always have bit 0 cleared, so only jal/branch can trip the 2-byte check
        if (!taken_s) begin
            trap_s = 1'b0;
        end else if (C_EXT) begin
            trap_s = ~jalr & jump_tgt_s[0];
        end else begin
            trap_s = jump_tgt_s[1];
        end
    end

    // Next-PC priority mux
    always_comb begin
        trap_win_s = 1'b0;
        if (halt) begin
            pc_d = pc_q;
        end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
        end else if (redir_valid) begin
            pc_d = redir_pc;
        end else if (trap_s) begin
            pc_d       = TRAP_VEC;
            trap_win_s = 1'b1;
        end else if (taken_s) begin
            pc_d = jump_tgt_s;
        end else begin
            pc_d = seq_pc_s;
        end
    end

    assign advance_s = ena & (state_q == ST_RUN) & pc_valid_q & pc_ready;

    // Control FSM, PC register, pending redirect and trap capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VEC;
            pc_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
            misalign_q   <= 1'b0;
            epc_q        <= {XLEN{1'b0}};
            bad_addr_q   <= {XLEN{1'b0}};
            pend_valid_q <= 1'b0;
            pend_pc_q    <= {XLEN{1'b0}};
        end else if (ena) begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_RUN;
                    pc_valid_q <= 1'b1;
                    if (redir_valid) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= redir_pc;
                    end
                end
                ST_RUN: begin
                    if (advance_s) begin
                        pc_q         <= pc_d;
                        pend_valid_q <= 1'b0;
                        if (halt) begin
                            state_q    <= ST_HALT;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end else if (trap_win_s) begin
                            epc_q      <= pc_q;
                            bad_addr_q <= jump_tgt_s;
                            misalign_q <= 1'b1;
                        end
                    end else if (redir_valid) begin
                        pend_valid_q <= 1'b1;
                        pend_pc_q    <= redir_pc;
                    end
                end
                ST_HALT: begin
                    pend_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end else begin
            misalign_q <= 1'b0;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign next_pc  = pc_d;
    assign taken    = taken_s;
    assign misalign = misalign_q;
    assign epc      = epc_q;
    assign bad_addr = bad_addr_q;
    assign halted   = halted_q;

endmodule
